regfile_ab_latch: RTL
=====================

# regfile_ab_latch

Register file with registered A/B operand latches for the multi-cycle RISC-V datapath. Holds 8 × 16-bit general registers (x0 hardwired to zero) and captures two source operands into the A and B latches. Those latches feed the 16-bit 2-input operand muxes (ALU source select) directly downstream. Writeback from the ALU-out / memory-data path enters through a single write port.

## Interface

Parameters:
- DATA_W, 16, register and operand width; must match the downstream mux width.
- ADDR_W, 3, register address width; register count = 2^ADDR_W (8).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- rs1_addr  input  ADDR_W  source register for the A latch.
- rs2_addr  input  ADDR_W  source register for the B latch.
- ab_en  input  1  latch-enable for A and B; asserted by control in the decode cycle.
- rd_addr  input  ADDR_W  destination register for writeback.
- wr_data  input  DATA_W  writeback data.
- wr_en  input  1  write enable.
- a_out  output  DATA_W  A operand latch, registered.
- b_out  output  DATA_W  B operand latch, registered.

## Operation

- Storage: regs[0..2^ADDR_W-1], DATA_W each.
  - regs[0] reads as 0 always.
  - Writes to address 0 are discarded; no storage for x0 is required.
- Write:
  - On a clk rising edge with wr_en=1 and rd_addr≠0, regs[rd_addr] ← wr_data.
  - wr_en=0 leaves all registers unchanged.
- Operand latch:
  - On a clk rising edge with ab_en=1:
    - a_out ← value(rs1_addr).
    - b_out ← value(rs2_addr).
  - With ab_en=0, a_out and b_out hold their values regardless of writes, including writes to the latched source register.
- value(r):
  - 0 if r=0.
  - Otherwise, wr_data if wr_en=1 and rd_addr=r (write-through bypass).
  - Otherwise, regs[r].
- Same-cycle write and latch to the same register: the latch captures the new wr_data, not the stale content. The bypass is suppressed when rd_addr=0.
- rs1_addr=rs2_addr is legal: a_out and b_out receive the same value.
- No internal state machine. Sequencing (fetch/decode/execute/writeback) is owned by control; this block only reacts to ab_en and wr_en per cycle.
- Writes are pure storage. There is no wrap or saturation; the full DATA_W value is stored as-is.

## Timing

- Reset (rst_n low): takes effect immediately, without waiting for clk.
  - All regs ← 0, a_out ← 0, b_out ← 0.
  - Outputs stay 0 while rst_n is low.
- Reset mid-operation: a write or latch on the same edge on which rst_n is low is lost. After release, all registers read 0.
- First active edge: the first rising edge after rst_n deasserts is a normal functional edge.
- Write latency:
  - A write issued on edge N is visible to a latch on edge N via the bypass.
  - From edge N+1 it is also visible through regs.
- Latch latency: a_out/b_out update one clk edge after ab_en is sampled high. Values are stable for the whole following cycle for the downstream mux.
- Outputs come directly from flops; there is no combinational path from any input to a_out/b_out.
- Inputs are sampled only at the rising edge; glitches between edges have no effect.

## Test plan

- Reset:
  - Stimulus: write 0x1234 to x3 and latch it, so a_out=0x1234. Pulse rst_n low for 3 ns, mid-cycle.
  - Required: a_out=b_out=0 immediately, without a clk edge. A subsequent latch of rs1=3 gives a_out=0x0000.
- Basic write/read:
  - Stimulus: write x1=0x0001, x2=0x8000, x7=0xFFFF on consecutive edges. Then latch rs1=7, rs2=2.
  - Required: a_out=0xFFFF and b_out=0x8000 one edge after ab_en.
- x0 immutability:
  - Stimulus: wr_en=1, rd=0, wr_data=0xBEEF. Then latch rs1=0, rs2=0.
  - Required: a_out=b_out=0x0000, including when the write and the latch share the same edge.
- Bypass:
  - Stimulus: x5=0x0AAA. On one edge, write rd=5, wr_data=0x5555 with ab_en=1, rs1=5, rs2=5.
  - Required: a_out=b_out=0x5555. A later latch of rs1=5 also reads 0x5555.
- Hold:
  - Stimulus: latch rs1=4 with x4=0x0010, giving a_out=0x0010. Then ab_en=0 and write x4=0x0020 for 5 cycles.
  - Required: a_out stays 0x0010. After ab_en=1, a_out=0x0020.
- Walking-ones sweep:
  - Stimulus: for k=1..7, write xk = 1<<k. Latch each pair (k, 8-k).
  - Required: a_out=1<<k and b_out=1<<(8-k), with b_out=0 when 8-k=8 would be out of range. All addresses are distinct and no aliasing occurs.

Source files
------------

// File: rtl/regfile_ab_latch_if.sv
// regfile_ab_latch_if: operand-fetch and writeback bundle of the regfile.
// master = control side (drives addresses/enables), slave = regfile.
interface regfile_ab_latch_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic              ab_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;

    modport master (
        output rs1_addr, rs2_addr, ab_en,
        output rd_addr, wr_data, wr_en,
        input  a_out, b_out
    );

    modport slave (
        input  rs1_addr, rs2_addr, ab_en,
        input  rd_addr, wr_data, wr_en,
        output a_out, b_out
    );
endinterface

// File: rtl/regfile_ab_latch.sv
// regfile_ab_latch: 2^ADDR_W x DATA_W register file, x0 reads zero,
// one write port with write-through bypass into registered A/B latches.
// Ports: clk, rst_n (async, active-low), bus (regfile_ab_latch_if.slave):
//   rs1_addr/rs2_addr/ab_en -> a_out/b_out, rd_addr/wr_data/wr_en -> regs.
module regfile_ab_latch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    regfile_ab_latch_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic              wr_ok;
    logic              a_zero;
    logic              b_zero;
    logic              a_hit;
    logic              b_hit;

    // x0 writes are dropped here, which also kills the bypass for rd=0.
    assign wr_ok  = bus.wr_en && (bus.rd_addr != '0);

    assign a_zero = (bus.rs1_addr == '0);
    assign b_zero = (bus.rs2_addr == '0);
    assign a_hit  = wr_ok && (bus.rd_addr == bus.rs1_addr);
    assign b_hit  = wr_ok && (bus.rd_addr == bus.rs2_addr);

    // zero and hit are exclusive since a hit needs rd != 0.
    always_comb begin
        a_nxt = regs[bus.rs1_addr];
        unique case (1'b1)
            a_zero:  a_nxt = '0;
            a_hit:   a_nxt = bus.wr_data;
            default: a_nxt = regs[bus.rs1_addr];
        endcase
    end

    always_comb begin
        b_nxt = regs[bus.rs2_addr];
        unique case (1'b1)
            b_zero:  b_nxt = '0;
            b_hit:   b_nxt = bus.wr_data;
            default: b_nxt = regs[bus.rs2_addr];
        endcase
    end

    // regs[0] is only ever reset, so it folds to a constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.rd_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.a_out <= '0;
            bus.b_out <= '0;
        end else if (bus.ab_en) begin
            bus.a_out <= a_nxt;
            bus.b_out <= b_nxt;
        end
    end
endmodule
